// File: rtl/muldiv_iter_if.sv
// muldiv_iter_if
//   Request/response bundle between the EX stage and the iterative multiply/divide
//   unit. The master side (pipeline) issues ops and consumes results; the slave side
//   is the unit itself.
//   Signals:
//     flush_i      kill the in-flight op
//     valid_i      request valid            ready_o   unit idle, can accept
//     op_i         4-bit op code            operand_a_i / operand_b_i  rs1 / rs2
//     valid_o      result valid             ready_i   consumer takes the result
//     result_o     XLEN-bit result
interface muldiv_iter_if #(
   parameter int XLEN = 64
);
   logic            flush_i;
   logic            valid_i;
   logic            ready_o;
   logic [3:0]      op_i;
   logic [XLEN-1:0] operand_a_i;
   logic [XLEN-1:0] operand_b_i;
   logic            valid_o;
   logic            ready_i;
   logic [XLEN-1:0] result_o;

   modport master (
      output flush_i, valid_i, op_i, operand_a_i, operand_b_i, ready_i,
      input  ready_o, valid_o, result_o
   );

   modport slave (
      input  flush_i, valid_i, op_i, operand_a_i, operand_b_i, ready_i,
      output ready_o, valid_o, result_o
   );
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter
//   Iterative RV M-extension unit (MUL/MULH*/DIV*/REM* plus the RV64 W variants),
//   one radix-2 step per clock. Divide-by-zero, signed overflow and reserved op
//   codes are resolved at accept and skip the iteration phase.
//   Ports:
//     clk_i   clock
//     rst_ni  asynchronous reset, active low
//     bus     muldiv_iter_if slave modport (handshakes, op, operands, result)
module muldiv_iter #(
   parameter int XLEN = 64
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   muldiv_iter_if.slave bus
);
   localparam int   CW    = $clog2(XLEN);
   localparam logic HAS_W = (XLEN == 64);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t            state_reg;
   logic [CW-1:0]     cnt_reg;
   logic              valid_reg;
   logic              ready_reg;
   logic [XLEN-1:0]   result_reg;
   logic              mul_reg, rem_reg, high_reg, w_reg, neg_reg;
   // Multiply: acc accumulates, mcand shifts left, mplier shifts right.
   // Divide:   acc = {remainder, dividend/quotient}, mcand[XLEN-1:0] = divisor.
   logic [2*XLEN-1:0] acc_reg, mcand_reg;
   logic [XLEN-1:0]   mplier_reg;

   // W results are the low word sign-extended, unsigned W ops included.
   function automatic logic [XLEN-1:0] fit_w(input logic [XLEN-1:0] v, input logic w);
      fit_w = w ? XLEN'($signed(v[31:0])) : v;
   endfunction

   // ---------------- op decode ----------------
   logic op_mul, op_div, op_rem, op_high, op_w, sgn_a, sgn_b;
   always_comb begin
      op_mul  = 1'b0;
      op_div  = 1'b0;
      op_rem  = 1'b0;
      op_high = 1'b0;
      op_w    = 1'b0;
      sgn_a   = 1'b0;
      sgn_b   = 1'b0;
      case (bus.op_i)
         4'd0:  op_mul = 1'b1;
         4'd1:  begin op_mul = 1'b1; op_high = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
         4'd2:  begin op_mul = 1'b1; op_high = 1'b1; sgn_a = 1'b1; end
         4'd3:  begin op_mul = 1'b1; op_high = 1'b1; end
         4'd4:  begin op_div = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
         4'd5:  op_div = 1'b1;
         4'd6:  begin op_rem = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
         4'd7:  op_rem = 1'b1;
         // W ops only exist on a 64-bit datapath; elsewhere they fall to reserved.
         4'd8:  begin op_mul = HAS_W; op_w = HAS_W; end
         4'd9:  begin op_div = HAS_W; op_w = HAS_W; sgn_a = HAS_W; sgn_b = HAS_W; end
         4'd10: begin op_div = HAS_W; op_w = HAS_W; end
         4'd11: begin op_rem = HAS_W; op_w = HAS_W; sgn_a = HAS_W; sgn_b = HAS_W; end
         4'd12: begin op_rem = HAS_W; op_w = HAS_W; end
         default: ;
      endcase
   end

   // ---------------- operand preparation and fast paths ----------------
   logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, fast_res;
   logic            a_neg, b_neg, div_zero, div_ovf, fast;
   always_comb begin
      if (op_w) begin
         a_ext = sgn_a ? XLEN'($signed(bus.operand_a_i[31:0])) : XLEN'(bus.operand_a_i[31:0]);
         b_ext = sgn_b ? XLEN'($signed(bus.operand_b_i[31:0])) : XLEN'(bus.operand_b_i[31:0]);
      end else begin
         a_ext = bus.operand_a_i;
         b_ext = bus.operand_b_i;
      end
      a_neg = sgn_a & a_ext[XLEN-1];
      b_neg = sgn_b & b_ext[XLEN-1];
      a_mag = a_neg ? -a_ext : a_ext;
      b_mag = b_neg ? -b_ext : b_ext;

      div_zero = (op_div | op_rem) && (b_ext == '0);
      div_ovf  = (op_div | op_rem) && sgn_a &&
                 (op_w ? ((bus.operand_a_i[31:0] == 32'h8000_0000) && (&bus.operand_b_i[31:0]))
                       : ((bus.operand_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.operand_b_i)));
      fast     = !(op_mul | op_div | op_rem) || div_zero || div_ovf;

      fast_res = '0;
      if (div_zero)
         fast_res = op_div ? '1 : a_ext;
      else if (div_ovf)
         fast_res = op_div ? a_ext : '0;
      fast_res = fit_w(fast_res, op_w);
   end

   // ---------------- one iteration step plus final fix-up ----------------
   logic [2*XLEN-1:0] acc_n, mcand_n, prod;
   logic [XLEN-1:0]   mplier_n, quo, rmd, calc_res;
   logic [XLEN:0]     shifted;
   logic              ge;
   always_comb begin
      acc_n    = acc_reg;
      mcand_n  = mcand_reg;
      mplier_n = mplier_reg;
      // Restoring step: bring in the next dividend bit, subtract if it fits.
      shifted  = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
      ge       = (shifted >= {1'b0, mcand_reg[XLEN-1:0]});
      if (mul_reg) begin
         if (mplier_reg[0])
            acc_n = acc_reg + mcand_reg;
         mcand_n  = mcand_reg << 1;
         mplier_n = mplier_reg >> 1;
      end else begin
         acc_n[2*XLEN-1:XLEN] = ge ? (shifted[XLEN-1:0] - mcand_reg[XLEN-1:0])
                                   : shifted[XLEN-1:0];
         acc_n[XLEN-1:0]      = {acc_reg[XLEN-2:0], ge};
      end
      // The result is taken from this step's output so it registers on the last edge.
      prod = neg_reg ? -acc_n : acc_n;
      quo  = neg_reg ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
      rmd  = neg_reg ? -acc_n[2*XLEN-1:XLEN] : acc_n[2*XLEN-1:XLEN];
      if (mul_reg)
         calc_res = high_reg ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
      else
         calc_res = rem_reg ? rmd : quo;
      calc_res = fit_w(calc_res, w_reg);
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         valid_reg  <= 1'b0;
         ready_reg  <= 1'b1;
         result_reg <= '0;
         mul_reg    <= 1'b0;
         rem_reg    <= 1'b0;
         high_reg   <= 1'b0;
         w_reg      <= 1'b0;
         neg_reg    <= 1'b0;
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
      end else if (bus.flush_i) begin
         state_reg <= IDLE;
         valid_reg <= 1'b0;
         ready_reg <= 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.valid_i && ready_reg) begin
                  mul_reg   <= op_mul;
                  rem_reg   <= op_rem;
                  high_reg  <= op_high;
                  w_reg     <= op_w;
                  neg_reg   <= op_rem ? a_neg : (a_neg ^ b_neg);
                  ready_reg <= 1'b0;
                  if (op_mul) begin
                     acc_reg    <= '0;
                     mcand_reg  <= {{XLEN{1'b0}}, a_mag};
                     mplier_reg <= b_mag;
                  end else begin
                     // W dividends are pre-aligned so 32 steps consume exactly their bits.
                     acc_reg    <= {{XLEN{1'b0}}, (op_w ? (a_mag << (XLEN-32)) : a_mag)};
                     mcand_reg  <= {{XLEN{1'b0}}, b_mag};
                     mplier_reg <= '0;
                  end
                  if (fast) begin
                     state_reg  <= DONE;
                     valid_reg  <= 1'b1;
                     result_reg <= fast_res;
                  end else begin
                     state_reg <= CALC;
                     cnt_reg   <= op_w ? CW'(31) : CW'(XLEN-1);
                  end
               end
            end
            CALC: begin
               acc_reg    <= acc_n;
               mcand_reg  <= mcand_n;
               mplier_reg <= mplier_n;
               if (cnt_reg == '0) begin
                  state_reg  <= DONE;
                  valid_reg  <= 1'b1;
                  result_reg <= calc_res;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            DONE: begin
               if (bus.ready_i) begin
                  state_reg <= IDLE;
                  valid_reg <= 1'b0;
                  ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               valid_reg <= 1'b0;
               ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready_o  = ready_reg;
   assign bus.valid_o  = valid_reg;
   assign bus.result_o = result_reg;
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter
//   Directed checks of muldiv_iter on a 64-bit and a 32-bit instance: results,
//   latency, fast paths, W ops, result hold, flush and asynchronous reset, plus a
//   short random run of ops 0-7 against a behavioural reference.
module tb_muldiv_iter;
   logic clk;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   muldiv_iter_if #(.XLEN(64)) bus64 ();
   muldiv_iter_if #(.XLEN(32)) bus32 ();

   muldiv_iter #(.XLEN(64)) dut64 (.clk_i(clk), .rst_ni(rst_n), .bus(bus64));
   muldiv_iter #(.XLEN(32)) dut32 (.clk_i(clk), .rst_ni(rst_n), .bus(bus32));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   // Issue one op on the 64-bit unit, check latency and result, then consume it.
   task automatic run64(input string tag, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat);
      int cyc;
      bus64.op_i        = op;
      bus64.operand_a_i = a;
      bus64.operand_b_i = b;
      bus64.valid_i     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus64.valid_i = 1'b0;
      cyc = 1;
      while (!bus64.valid_o && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      $display("[TB] x64 %s op=%0d a=0x%h b=0x%h res=0x%h lat=%0d", tag, op, a, b, bus64.result_o, cyc);
      check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
      check(tag, bus64.result_o, exp_res);
      bus64.ready_i = 1'b1;
      @(negedge clk);
      bus64.ready_i = 1'b0;
   endtask

   task automatic run32(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int cyc;
      bus32.op_i        = op;
      bus32.operand_a_i = a;
      bus32.operand_b_i = b;
      bus32.valid_i     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus32.valid_i = 1'b0;
      cyc = 1;
      while (!bus32.valid_o && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      $display("[TB] x32 %s op=%0d a=0x%h b=0x%h res=0x%h lat=%0d", tag, op, a, b, bus32.result_o, cyc);
      check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
      check(tag, 64'(bus32.result_o), 64'(exp_res));
      bus32.ready_i = 1'b1;
      @(negedge clk);
      bus32.ready_i = 1'b0;
   endtask

   // Behavioural reference for ops 0-7 on XLEN=64.
   function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
      logic [127:0] p;
      logic         ovf;
      ovf = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
      case (op)
         4'd0: ref_model = a * b;
         4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; ref_model = p[127:64]; end
         4'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       ref_model = p[127:64]; end
         4'd3: begin p = {64'd0, a} * {64'd0, b};             ref_model = p[127:64]; end
         4'd4: ref_model = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf ? a : 64'($signed(a) / $signed(b));
         4'd5: ref_model = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
         4'd6: ref_model = (b == 0) ? a : ovf ? 64'd0 : 64'($signed(a) % $signed(b));
         4'd7: ref_model = (b == 0) ? a : a % b;
         default: ref_model = 64'd0;
      endcase
   endfunction

   initial begin
      int          cyc;
      logic        saw_valid;
      logic [3:0]  rop;
      logic [63:0] ra, rb;
      int          rlat;

      rst_n = 1'b0;
      bus64.flush_i = 1'b0; bus64.valid_i = 1'b0; bus64.ready_i = 1'b0;
      bus64.op_i = 4'd0; bus64.operand_a_i = '0; bus64.operand_b_i = '0;
      bus32.flush_i = 1'b0; bus32.valid_i = 1'b0; bus32.ready_i = 1'b0;
      bus32.op_i = 4'd0; bus32.operand_a_i = '0; bus32.operand_b_i = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(bus64.ready_o), 64'd1);
      check("rst_valid", 64'(bus64.valid_o), 64'd0);
      check("rst_result", bus64.result_o, 64'd0);
      check("rst_ready32", 64'(bus32.ready_o), 64'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed 64-bit vectors
      run64("mul",      4'd0,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
      run64("mulhu",    4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      run64("mulh",     4'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65);
      run64("div",      4'd4,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
      run64("rem",      4'd6,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      run64("divu",     4'd5,  64'd100, 64'd7, 64'd14, 65);
      run64("remu",     4'd7,  64'd100, 64'd7, 64'd2, 65);
      run64("divu_z",   4'd5,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      run64("rem_ovf",  4'd6,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
      run64("div_ovf",  4'd4,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
      run64("divw_ovf", 4'd9,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
      run64("mulw",     4'd8,  64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
      run64("divuw",    4'd10, 64'h1234_5678_8000_0000, 64'hABCD_0000_0000_0002, 64'h0000_0000_4000_0000, 33);
      run64("remw",     4'd11, 64'h0000_0000_FFFF_FFF9, 64'h0000_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 33);
      run64("remuw_z",  4'd12, 64'hDEAD_BEEF_FFFF_FFFF, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      run64("rsvd",     4'd13, 64'd123, 64'd456, 64'd0, 1);

      // Result held while the consumer stalls
      bus64.op_i = 4'd0; bus64.operand_a_i = 64'd3; bus64.operand_b_i = 64'd5; bus64.valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus64.valid_i = 1'b0;
      cyc = 1;
      while (!bus64.valid_o && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("hold_lat", 64'(cyc), 64'd65);
      for (int i = 0; i < 5; i++) begin
         check("hold_res", bus64.result_o, 64'd15);
         check("hold_rdy", 64'(bus64.ready_o), 64'd0);
         @(negedge clk);
      end
      check("hold_valid", 64'(bus64.valid_o), 64'd1);
      $display("[TB] x64 hold res=0x%h", bus64.result_o);
      bus64.ready_i = 1'b1;
      @(negedge clk);
      bus64.ready_i = 1'b0;

      // Flush in CALC at t0+10
      bus64.op_i = 4'd4; bus64.operand_a_i = 64'd1000; bus64.operand_b_i = 64'd3; bus64.valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus64.valid_i = 1'b0;
      repeat (9) @(negedge clk);
      bus64.flush_i = 1'b1;
      @(negedge clk);
      bus64.flush_i = 1'b0;
      check("flush_ready", 64'(bus64.ready_o), 64'd1);
      check("flush_valid", 64'(bus64.valid_o), 64'd0);
      saw_valid = 1'b0;
      for (int i = 0; i < 70; i++) begin
         if (bus64.valid_o) saw_valid = 1'b1;
         @(negedge clk);
      end
      check("flush_quiet", 64'(saw_valid), 64'd0);
      $display("[TB] x64 flush done ready=%0d", bus64.ready_o);

      // Async reset at t0+20 of a running op
      bus64.op_i = 4'd0; bus64.operand_a_i = 64'd9; bus64.operand_b_i = 64'd9; bus64.valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus64.valid_i = 1'b0;
      repeat (19) @(negedge clk);
      check("pre_rst_res", bus64.result_o, 64'd15);
      #1 rst_n = 1'b0;
      #1;
      check("arst_ready", 64'(bus64.ready_o), 64'd1);
      check("arst_valid", 64'(bus64.valid_o), 64'd0);
      check("arst_result", bus64.result_o, 64'd0);
      $display("[TB] x64 async reset mid-op");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run64("post_rst", 4'd0, 64'd9, 64'd9, 64'd81, 65);

      // Random ops 0-7 against the reference
      for (int i = 0; i < 20; i++) begin
         rop = 4'($urandom_range(0, 7));
         ra  = {$urandom, $urandom};
         rb  = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: rb = 64'd0;
            1: rb = 64'($urandom_range(1, 20));
            2: begin ra = 64'h8000_0000_0000_0000; rb = 64'hFFFF_FFFF_FFFF_FFFF; end
            3: ra = 64'($urandom_range(0, 1000));
            default: ;
         endcase
         rlat = 65;
         if (rop >= 4'd4 && (rb == 64'd0 ||
             ((rop == 4'd4 || rop == 4'd6) && ra == 64'h8000_0000_0000_0000 && rb == 64'hFFFF_FFFF_FFFF_FFFF)))
            rlat = 1;
         run64($sformatf("rand%0d", i), rop, ra, rb, ref_model(rop, ra, rb), rlat);
      end

      // 32-bit instance
      run32("mulh32", 4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
      run32("div32",  4'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run32("remu32", 4'd7, 32'd100, 32'd0, 32'd100, 1);
      run32("w_rsvd32", 4'd8, 32'd7, 32'd3, 32'd0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
